// File: rtl/mem_pattern_tester.sv
// Self-checking SDRAM exerciser: writes P(i) = {~i, i} over a word window, reads every
// word back through the controller request port and tallies compares and mismatches.
module mem_pattern_tester #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 256,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_ready,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [2:0]        check_sel,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              we,
    output logic              oe,
    output logic [DATA_W-1:0] read_value,
    output logic [7:0]        tested,
    output logic [7:0]        error,
    output logic              finish,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    localparam int                TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0]        LAST = 8'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT);

    function automatic logic [DATA_W-1:0] pattern(input logic [7:0] i);
        return DATA_W'({~i, i});
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] i);
        return BASE + ADDR_W'(i);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state, state_n;
    logic [7:0]        idx, idx_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n, read_value_n;
    logic              we_n, oe_n, finish_n, busy_n;
    logic [7:0]        tested_n, error_n;
    logic              accept, step;
    logic [7:0]        idx_inc;

    assign accept  = (we | oe) & mem_ready;
    assign idx_inc = idx + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Outputs are computed one step ahead so every port comes straight from a flop.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        tcnt_n       = tcnt;
        addr_n       = addr;
        data_n       = data;
        we_n         = we;
        oe_n         = oe;
        read_value_n = read_value;
        tested_n     = tested;
        error_n      = error;
        finish_n     = finish;
        step         = 1'b0;

        case (state)
            S_IDLE: begin
                we_n     = 1'b0;
                oe_n     = 1'b0;
                addr_n   = '0;
                data_n   = '0;
                finish_n = 1'b0;
                if (start) begin
                    tested_n     = '0;
                    error_n      = '0;
                    read_value_n = '0;
                    idx_n        = '0;
                    state_n      = S_WRITE;
                    we_n         = 1'b1;
                    addr_n       = word_addr(8'd0);
                    data_n       = pattern(8'd0);
                end
            end
            S_WRITE: begin
                if (accept) begin
                    if (idx == LAST) begin
                        idx_n   = '0;
                        state_n = S_READ_REQ;
                        we_n    = 1'b0;
                        oe_n    = 1'b1;
                        addr_n  = word_addr(8'd0);
                        data_n  = '0;
                    end else begin
                        idx_n  = idx_inc;
                        addr_n = word_addr(idx_inc);
                        data_n = pattern(idx_inc);
                    end
                end
            end
            S_READ_REQ: begin
                if (accept) begin
                    oe_n    = 1'b0;
                    tcnt_n  = '0;
                    state_n = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                // Valid data takes priority over a timeout landing in the same cycle.
                if (mem_valid) begin
                    tested_n = sat_inc(tested);
                    if (mem_data != pattern(idx)) error_n = sat_inc(error);
                    if (idx == {5'b0, check_sel}) read_value_n = mem_data;
                    step = 1'b1;
                end else if (tcnt == TMAX) begin
                    error_n = sat_inc(error);
                    step    = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
                if (step) begin
                    if (idx == LAST) begin
                        state_n  = S_DONE;
                        finish_n = 1'b1;
                        addr_n   = '0;
                    end else begin
                        idx_n   = idx_inc;
                        state_n = S_READ_REQ;
                        oe_n    = 1'b1;
                        addr_n  = word_addr(idx_inc);
                    end
                end
            end
            S_DONE: begin
                finish_n = 1'b1;
                if (!start) begin
                    state_n  = S_IDLE;
                    finish_n = 1'b0;
                end
            end
            default: begin
                state_n  = S_IDLE;
                we_n     = 1'b0;
                oe_n     = 1'b0;
                finish_n = 1'b0;
            end
        endcase

        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            tcnt       <= '0;
            addr       <= '0;
            data       <= '0;
            we         <= 1'b0;
            oe         <= 1'b0;
            read_value <= '0;
            tested     <= '0;
            error      <= '0;
            finish     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            idx        <= idx_n;
            tcnt       <= tcnt_n;
            addr       <= addr_n;
            data       <= data_n;
            we         <= we_n;
            oe         <= oe_n;
            read_value <= read_value_n;
            tested     <= tested_n;
            error      <= error_n;
            finish     <= finish_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Scoreboarded bench for mem_pattern_tester: a memory model answers requests, expected
// writes/reads/results are queued by the stimulus and popped by a posedge monitor.
module tb_mem_pattern_tester;

    localparam int AW = 22;
    localparam int NW = 8;
    localparam int TO = 15;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_valid = 1'b0;
    logic [15:0]   mem_data  = 16'hDEAD;
    logic [2:0]    check_sel = 3'd0;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          we, oe;
    logic [15:0]   read_value;
    logic [7:0]    tested, error;
    logic          finish, busy;

    always #5 clk = ~clk;

    mem_pattern_tester #(
        .ADDR_W(AW), .DATA_W(16), .BASE_ADDR(0), .NUM_WORDS(NW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .check_sel(check_sel),
        .addr(addr), .data(data), .we(we), .oe(oe), .read_value(read_value),
        .tested(tested), .error(error), .finish(finish), .busy(busy)
    );

    typedef struct { logic [AW-1:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic [7:0] t; logic [7:0] e; logic [15:0] rv; } res_t;

    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    res_t          res_q[$];

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:255];
    int          rd_count   = 0;
    logic [15:0] rd_word    = '0;
    bit          corrupt    = 0;
    bit          no_valid   = 0;
    bit          rand_ready = 0;

    function automatic logic [15:0] p(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {~b, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model driver: new ready/valid values are presented on the falling edge.
    initial forever begin
        @(negedge clk);
        mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_valid = 1'b0;
        mem_data  = 16'hDEAD;
        if (rd_count > 0) begin
            rd_count--;
            if (rd_count == 0 && !no_valid) begin
                mem_valid = 1'b1;
                mem_data  = rd_word;
            end
        end
    end

    // Monitor: observes acceptances and the finish edge, pops expectations and compares.
    initial begin
        bit            stab_pend = 0;
        logic [AW-1:0] stab_addr = '0;
        logic [15:0]   stab_data = '0;
        logic          stab_we   = 0;
        logic          fin_prev  = 0;
        wr_t           w;
        res_t          r;
        logic [AW-1:0] ra;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                stab_pend = 0;
                fin_prev  = 0;
                rd_count  = 0;
            end else begin
                if (stab_pend) begin
                    chk("stable_addr", 32'(addr), 32'(stab_addr));
                    chk("stable_data", 32'(data), 32'(stab_data));
                    chk("stable_we",   32'(we),   32'(stab_we));
                end
                stab_pend = (we | oe) && !mem_ready;
                stab_addr = addr;
                stab_data = data;
                stab_we   = we;
                if (we && mem_ready) begin
                    if (wr_q.size() == 0) begin
                        total++; bad++;
                        $display("[TB] FAIL unexpected_write: got addr %h expected none", addr);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", 32'(addr), 32'(w.a));
                        chk("wr_data", 32'(data), 32'(w.d));
                    end
                    mem[addr[7:0]] = (corrupt && addr[7:0] == 8'd3) ? 16'h0000 : data;
                end
                if (oe && mem_ready) begin
                    if (rd_q.size() == 0) begin
                        total++; bad++;
                        $display("[TB] FAIL unexpected_read: got addr %h expected none", addr);
                    end else begin
                        ra = rd_q.pop_front();
                        chk("rd_addr", 32'(addr), 32'(ra));
                    end
                    rd_word  = mem[addr[7:0]];
                    rd_count = 2;
                end
                if (finish && !fin_prev) begin
                    if (res_q.size() == 0) begin
                        total++; bad++;
                        $display("[TB] FAIL unexpected_finish: got finish expected none");
                    end else begin
                        r = res_q.pop_front();
                        chk("tested",     32'(tested),     32'(r.t));
                        chk("error",      32'(error),      32'(r.e));
                        chk("read_value", 32'(read_value), 32'(r.rv));
                        chk("busy_done",  32'(busy),       32'd0);
                    end
                end
                fin_prev = finish;
            end
        end
    end

    task automatic checkOutput(input string tag);
        chk({tag, "_addr"},       32'(addr),       0);
        chk({tag, "_data"},       32'(data),       0);
        chk({tag, "_we"},         32'(we),         0);
        chk({tag, "_oe"},         32'(oe),         0);
        chk({tag, "_read_value"}, 32'(read_value), 0);
        chk({tag, "_tested"},     32'(tested),     0);
        chk({tag, "_error"},      32'(error),      0);
        chk({tag, "_finish"},     32'(finish),     0);
        chk({tag, "_busy"},       32'(busy),       0);
    endtask

    task automatic waitFinish();
        int n = 0;
        while (!finish && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!finish) begin
            bad++;
            $display("[TB] FAIL finish_timeout: got finish=0 expected 1 within 2000 cycles");
        end
        @(negedge clk);
        chk("queues_drained", 32'(wr_q.size() + rd_q.size() + res_q.size()), 0);
    endtask

    task automatic applyStimulus(input int sel, input bit bad3, input bit novalid,
                                 input bit rnd, input bit hold);
        res_t r;
        corrupt    = bad3;
        no_valid   = novalid;
        rand_ready = rnd;
        check_sel  = 3'(sel);
        for (int i = 0; i < NW; i++) begin
            wr_q.push_back('{a: AW'(i), d: p(i)});
            rd_q.push_back(AW'(i));
        end
        r.t  = novalid ? 8'd0 : 8'd8;
        r.e  = novalid ? 8'd8 : (bad3 ? 8'd1 : 8'd0);
        r.rv = novalid ? 16'h0000 : ((bad3 && sel == 3) ? 16'h0000 : p(sel));
        res_q.push_back(r);
        start = 1'b1;
        @(negedge clk);
        chk("start_we",     32'(we),     1);
        chk("start_tested", 32'(tested), 0);
        chk("start_error",  32'(error),  0);
        chk("start_busy",   32'(busy),   1);
        if (!hold) start = 1'b0;
        waitFinish();
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] ideal run, start held through DONE");
        applyStimulus(5, 0, 0, 0, 1);
        repeat (30) @(negedge clk);
        chk("held_finish", 32'(finish), 1);
        chk("held_we",     32'(we),     0);
        start = 1'b0;
        @(negedge clk);
        chk("drop_finish", 32'(finish), 0);

        $display("[TB] corrupted word 3");
        applyStimulus(3, 1, 0, 0, 0);

        $display("[TB] random ready");
        applyStimulus(7, 0, 0, 1, 0);
        rand_ready = 0;

        $display("[TB] no read data, timeouts");
        applyStimulus(0, 0, 1, 0, 0);
        no_valid = 0;

        $display("[TB] reset during write at index 4");
        corrupt = 0;
        for (int i = 0; i < 4; i++) wr_q.push_back('{a: AW'(i), d: p(i)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(we && addr == AW'(4)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_index4", 32'(addr), 4);
        rst_n = 1'b0;
        #1 checkOutput("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_drained", 32'(wr_q.size()), 0);

        $display("[TB] restart after reset");
        applyStimulus(2, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
